// File: rtl/motion_compensator.sv
// Motion compensator: fetches the 16x16 block at (motionX, motionY) from the 32x32
// search window, adds a signed residual, clamps to 0..255, writes the result in raster order.
module motion_compensator #(
   parameter int BLK = 16,
   parameter int WIN = 32
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] motionX,
   input  logic [3:0] motionY,
   output logic [9:0] AddressS,
   input  logic [7:0] S,
   output logic [7:0] AddressD,
   input  logic [8:0] D,
   output logic [7:0] AddressW,
   output logic [7:0] W,
   output logic       we,
   output logic [8:0] satCount,
   output logic       busy,
   output logic       completed
);

   // state | meaning
   // IDLE  | waiting for start
   // RUN   | issuing read addresses for pixels 0..255
   // DRAIN | addresses done, pipeline still writing
   // DONE  | block written, wait for start to drop
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [7:0] LAST_PIX = 8'(BLK * BLK - 1);

   state_t     state_q, state_d;
   logic [3:0] mx_q, mx_d;
   logic [3:0] my_q, my_d;
   logic [7:0] p_q, p_d;
   logic [9:0] addr_s_q, addr_s_d;
   logic       addr_v_q, addr_v_d;
   logic       v1_q, v1_d;
   logic [7:0] wa1_q, wa1_d;
   logic [7:0] w_q, w_d;
   logic [7:0] aw_q, aw_d;
   logic       we_q, we_d;
   logic [8:0] sat_q, sat_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [9:0] sum;

   function automatic logic [9:0] win_addr(input logic [3:0] y, input logic [3:0] x,
                                           input logic [7:0] pix);
      logic [9:0] r;
      logic [9:0] c;
      r = 10'(y) + 10'(pix[7:4]);
      c = 10'(x) + 10'(pix[3:0]);
      return (r * 10'(WIN)) + c;
   endfunction

   // S arrives one clock after its address, so stage 1 only needs to carry the pixel index.
   assign sum = {2'b00, S} + {D[8], D};

   always_comb begin
      state_d  = state_q;
      mx_d     = mx_q;
      my_d     = my_q;
      p_d      = p_q;
      addr_s_d = addr_s_q;
      addr_v_d = addr_v_q;
      v1_d     = addr_v_q;
      wa1_d    = p_q;
      w_d      = w_q;
      aw_d     = aw_q;
      we_d     = v1_q;
      sat_d    = sat_q;
      busy_d   = busy_q;
      done_d   = done_q;

      if (v1_q) begin
         aw_d = wa1_q;
         if (sum[9]) begin
            w_d   = 8'd0;
            sat_d = sat_q + 9'd1;
         end else if (sum[8]) begin
            w_d   = 8'd255;
            sat_d = sat_q + 9'd1;
         end else begin
            w_d = sum[7:0];
         end
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = RUN;
               mx_d     = motionX;
               my_d     = motionY;
               p_d      = 8'd0;
               addr_s_d = win_addr(motionY, motionX, 8'd0);
               addr_v_d = 1'b1;
               sat_d    = 9'd0;
               busy_d   = 1'b1;
            end
         end
         RUN: begin
            if (p_q == LAST_PIX) begin
               state_d  = DRAIN;
               addr_v_d = 1'b0;
            end else begin
               p_d      = p_q + 8'd1;
               addr_s_d = win_addr(my_q, mx_q, p_q + 8'd1);
            end
         end
         DRAIN: begin
            if (we_q && (aw_q == LAST_PIX)) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            if (!start) begin
               state_d = IDLE;
               done_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         mx_q     <= 4'd0;
         my_q     <= 4'd0;
         p_q      <= 8'd0;
         addr_s_q <= 10'd0;
         addr_v_q <= 1'b0;
         v1_q     <= 1'b0;
         wa1_q    <= 8'd0;
         w_q      <= 8'd0;
         aw_q     <= 8'd0;
         we_q     <= 1'b0;
         sat_q    <= 9'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mx_q     <= mx_d;
         my_q     <= my_d;
         p_q      <= p_d;
         addr_s_q <= addr_s_d;
         addr_v_q <= addr_v_d;
         v1_q     <= v1_d;
         wa1_q    <= wa1_d;
         w_q      <= w_d;
         aw_q     <= aw_d;
         we_q     <= we_d;
         sat_q    <= sat_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign AddressS  = addr_s_q;
   assign AddressD  = p_q;
   assign AddressW  = aw_q;
   assign W         = w_q;
   assign we        = we_q;
   assign satCount  = sat_q;
   assign busy      = busy_q;
   assign completed = done_q;

endmodule

// File: tb/tb_motion_compensator.sv
// Bench for motion_compensator: synchronous-read memory models plus an arithmetic
// reference of the reconstructed block, checked cycle by cycle against the DUT.
module tb_motion_compensator;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] motionX, motionY;
   logic [9:0] AddressS;
   logic [7:0] S;
   logic [7:0] AddressD;
   logic [8:0] D;
   logic [7:0] AddressW;
   logic [7:0] W;
   logic       we;
   logic [8:0] satCount;
   logic       busy;
   logic       completed;

   int checks   = 0;
   int failures = 0;

   logic [7:0] smem [0:1023];
   logic [8:0] dmem [0:255];

   motion_compensator dut (
      .clock(clock), .reset(reset), .start(start),
      .motionX(motionX), .motionY(motionY),
      .AddressS(AddressS), .S(S), .AddressD(AddressD), .D(D),
      .AddressW(AddressW), .W(W), .we(we), .satCount(satCount),
      .busy(busy), .completed(completed)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      S <= smem[AddressS];
      D <= dmem[AddressD];
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_addr(input int mx, input int my, input int pix);
      return (my + pix / 16) * 32 + (mx + pix % 16);
   endfunction

   // One full block; start dropped after E0 unless hold is set, then a one-cycle start=0 gap.
   task automatic run_block(input logic [3:0] mx, input logic [3:0] my, input bit hold);
      int exp_sat, nw, s, d, sm, ew;
      exp_sat = 0;
      nw      = 0;
      @(negedge clock);
      motionX = mx;
      motionY = my;
      start   = 1'b1;
      @(posedge clock);
      @(negedge clock);
      if (!hold) start = 1'b0;
      motionX = ~mx;
      motionY = ~my;
      check("addr_s_first", 32'(AddressS), 32'(ref_addr(mx, my, 0)));
      check("busy_run", 32'(busy), 32'd1);
      for (int k = 1; k <= 258; k++) begin
         @(posedge clock);
         @(negedge clock);
         if (k <= 255) begin
            check("addr_s", 32'(AddressS), 32'(ref_addr(mx, my, k)));
            check("addr_d", 32'(AddressD), 32'(k));
         end
         check("we_timing", 32'(we), 32'((k >= 2 && k <= 257) ? 1 : 0));
         check("busy", 32'(busy), 32'((k <= 257) ? 1 : 0));
         if (we === 1'b1) begin
            nw++;
            s  = int'(smem[ref_addr(mx, my, k - 2)]);
            d  = int'($signed(dmem[k - 2]));
            sm = s + d;
            if (sm < 0) begin
               ew = 0;
               exp_sat++;
            end else if (sm > 255) begin
               ew = 255;
               exp_sat++;
            end else begin
               ew = sm;
            end
            check("addr_w", 32'(AddressW), 32'(k - 2));
            check("w_value", 32'(W), 32'(ew));
         end
      end
      check("completed", 32'(completed), 32'd1);
      check("sat_count", 32'(satCount), 32'(exp_sat));
      check("write_count", 32'(nw), 32'd256);
      if (hold) begin
         for (int k = 0; k < 20; k++) begin
            @(posedge clock);
            @(negedge clock);
            check("hold_completed", 32'(completed), 32'd1);
            check("hold_no_we", 32'(we), 32'd0);
         end
      end
      start = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check("back_to_idle", 32'(completed), 32'd0);
      check("idle_we", 32'(we), 32'd0);
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      motionX = 4'd0;
      motionY = 4'd0;
      for (int i = 0; i < 1024; i++) smem[i] = 8'(i);
      for (int i = 0; i < 256; i++) dmem[i] = 9'd0;

      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_we", 32'(we), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_completed", 32'(completed), 32'd0);
      check("rst_addr_s", 32'(AddressS), 32'd0);
      check("rst_addr_w", 32'(AddressW), 32'd0);
      check("rst_w", 32'(W), 32'd0);
      check("rst_sat", 32'(satCount), 32'd0);
      reset = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("idle_busy", 32'(busy), 32'd0);

      // address-pattern window, zero residual, zero offset
      run_block(4'd0, 4'd0, 1'b0);

      // maximal offset, random data
      for (int i = 0; i < 1024; i++) smem[i] = 8'($urandom);
      for (int i = 0; i < 256; i++) dmem[i] = 9'($urandom);
      run_block(4'd15, 4'd15, 1'b0);

      // every pixel saturates
      for (int i = 0; i < 1024; i++) smem[i] = 8'd250;
      for (int i = 0; i < 256; i++) dmem[i] = (i % 2 == 0) ? 9'd10 : 9'h100;
      run_block(4'($urandom_range(15)), 4'($urandom_range(15)), 1'b0);

      // reset mid-block
      for (int i = 0; i < 1024; i++) smem[i] = 8'($urandom);
      for (int i = 0; i < 256; i++) dmem[i] = 9'($urandom);
      @(negedge clock);
      motionX = 4'd5;
      motionY = 4'd7;
      start   = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      repeat (100) @(posedge clock);
      @(negedge clock);
      check("pre_reset_we", 32'(we), 32'd1);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("mid_rst_we", 32'(we), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_sat", 32'(satCount), 32'd0);
      check("mid_rst_addr_w", 32'(AddressW), 32'd0);
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clock);
         @(negedge clock);
         check("post_rst_quiet", 32'({we, busy, completed}), 32'd0);
      end

      // restart after reset, hold start through DONE, then a second latched vector
      run_block(4'd3, 4'd2, 1'b1);
      for (int i = 0; i < 256; i++) dmem[i] = 9'($urandom);
      run_block(4'($urandom_range(15)), 4'($urandom_range(15)), 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/motion_compensator.md
Name: motion_compensator

Overview:
- Decoder-side counterpart of the motion estimator.
- Takes the motion vector (motionX, motionY) the estimator produces, fetches the matching 16x16 block from the 32x32 search-window memory, and adds a signed residual block.
- Writes the reconstructed 16x16 block to a frame-buffer port in raster order.
- Uses the same synchronous-read ROM interface style as the estimator: address out, data back one clock later.

Parameters:
- BLK, 16, block width/height in pixels (fixed; addressing below assumes 16).
- WIN, 32, search-window row pitch in pixels.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level request; sampled in IDLE to begin a block.
- motionX  in  4  horizontal offset 0..15 into the search window.
- motionY  in  4  vertical offset 0..15 into the search window.
- AddressS  out  10  search-window read address.
- S  in  8  search-window pixel; valid one clock after AddressS.
- AddressD  out  8  residual-memory read address.
- D  in  9  signed residual (two's complement, -256..255); valid one clock after AddressD.
- AddressW  out  8  reconstructed-block write address.
- W  out  8  reconstructed pixel.
- we  out  1  write strobe for W/AddressW.
- satCount  out  9  number of clamped pixels in the current/last block.
- busy  out  1  high in RUN and DRAIN.
- completed  out  1  high in DONE.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counter and pipeline valid bits cleared.
- Reset is asserted synchronously and takes effect at any point, including mid-block. It forces IDLE and we=0 from the next edge, and no further writes occur.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on an edge with start=1.
  - At that edge: latch motionX/motionY into mx/my, clear pixel counter p (0..255), clear satCount.
  - motionX/motionY changes after the latch are ignored until the next start.
- RUN, pixel p: row=p[7:4], col=p[3:0].
  - AddressS = (my+row)*32 + (mx+col). Maximum value is 990, so no wrap in 10 bits.
  - AddressD = p.
  - Address outputs are registered: addresses for pixel 0 appear in the cycle after the start-sampling edge, and p increments once per clock.
- RUN -> DRAIN on the edge that advances past p=255.
- Pipeline: two stages, each tracked by a valid bit.
  - Stage 1: memory data S/D for the address issued in the previous cycle is captured together with its write address.
  - Stage 2: sum computed, then W, AddressW and we are registered.
  - The write for pixel p has we=1 exactly two cycles after its address is driven.
- Arithmetic: sum = {2'b0,S} + sign-extended D, in 10-bit signed.
  - sum < 0 gives W=0; sum > 255 gives W=255; otherwise W=sum[7:0].
  - Each clamp increments satCount (max 256, fits 9 bits).
- DRAIN: hold until the last write (AddressW=255, we=1) has issued, then enter DONE at the following edge.
  - Start-sampling edge = E0. Writes occur for exactly 256 consecutive cycles, registered at edges E2..E257.
  - completed rises at E258; busy falls at the same edge.
- DONE: completed=1, we=0, outputs W/AddressW hold their last values. DONE -> IDLE on an edge with start=0.
  - A start held high never retriggers, so one request produces exactly one block.
- start is ignored in RUN/DRAIN.
- AddressW sequence is strictly 0..255 with no gaps or repeats.

Test Plan:
- Reset, start=0 for 3 cycles -> all outputs 0, busy=0, we=0.
- motionX=0, motionY=0, S = address-low-byte pattern, D=0:
  - W equals S at (row*32+col) for each AddressW.
  - First we at E2, completed at E258, satCount=0.
- motionX=15, motionY=15:
  - First AddressS=495, last AddressS=990.
  - AddressW runs 0..255 contiguous, with exactly 256 we pulses.
- S=250 everywhere, D=+10 for p even, D=-300-clamped patterns (D=-256) for p odd:
  - W=255 for even p, W=0 for odd p, satCount=256.
- Assert reset at E100 mid-block -> we=0 from E101, state IDLE.
  - Restarting with motionX=3, motionY=2 gives first AddressS=67 and a clean full block.
- Hold start=1 after completion -> completed stays 1, no new writes.
  - Drop start for one cycle then raise it -> second block runs with the newly latched vector.
